// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue: PC generation, valid/ready imem requests, DEPTH-entry prefetch queue toward decode (stats under FETCH_STATS_EN).
// Latency: memory latency + 1 from request acceptance to instr_valid (no bypass path).
// Backpressure: requests stall while buffered + in-flight reaches DEPTH; a redirect gates both handshakes for its cycle.
module cpu_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            jal,
    input  logic            jalr,
    input  logic            branch,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc_out
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]     stat_redirects,
    output logic [31:0]     stat_starve
`endif
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW:0]   DEPTH_V = (CW+1)'(DEPTH);

    logic [XLEN-1:0] q_dat [DEPTH];
    logic [XLEN-1:0] q_pc  [DEPTH];
    logic [XLEN-1:0] pcq   [DEPTH];
    logic [PW-1:0]   q_wr, q_rd, pcq_wr, pcq_rd;
    logic [CW-1:0]   count, outstanding, drop_cnt;
    logic [XLEN-1:0] fetch_pc;
    logic            run;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            req_acc, rsp_push, rsp_drop, deq;

    always_comb begin
        redirect = jalr | jal | (branch & branch_taken);
        target   = jalr ? jalr_target : branch_target;
        target[1:0] = 2'b00;
        // Doomed requests still hold credit so drop_cnt never exceeds DEPTH.
        imem_req_valid = run & ~redirect
                       & (({1'b0, count} + {1'b0, outstanding}) < DEPTH_V)
                       & (({1'b0, outstanding} + {1'b0, drop_cnt}) < DEPTH_V);
        imem_req_addr  = fetch_pc;
        req_acc        = imem_req_valid & imem_req_ready;
        rsp_drop       = imem_rsp_valid & (drop_cnt != '0);
        rsp_push       = imem_rsp_valid & (drop_cnt == '0) & ~redirect;
        instr_valid    = (count != '0) & ~redirect;
        deq            = instr_valid & instr_ready;
        instr          = q_dat[q_rd];
        pc_out         = q_pc[q_rd];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_dat[i] <= '0;
                q_pc[i]  <= '0;
                pcq[i]   <= '0;
            end
            q_wr        <= '0;
            q_rd        <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            fetch_pc    <= RESET_PC;
            run         <= 1'b0;
        end else begin
            run <= 1'b1;
            if (redirect) begin
                // Everything still in flight at this edge belongs to the old path.
                fetch_pc    <= target;
                q_wr        <= '0;
                q_rd        <= '0;
                pcq_wr      <= '0;
                pcq_rd      <= '0;
                count       <= '0;
                outstanding <= '0;
                drop_cnt    <= drop_cnt + outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_acc) begin
                    fetch_pc    <= fetch_pc + XLEN'(4);
                    pcq[pcq_wr] <= fetch_pc;
                    pcq_wr      <= pcq_wr + PW'(1);
                end
                if (rsp_push) begin
                    q_dat[q_wr] <= imem_rsp_data;
                    q_pc[q_wr]  <= pcq[pcq_rd];
                    q_wr        <= q_wr + PW'(1);
                    pcq_rd      <= pcq_rd + PW'(1);
                end
                if (deq)
                    q_rd <= q_rd + PW'(1);
                count       <= count + CW'(rsp_push) - CW'(deq);
                outstanding <= outstanding + CW'(req_acc) - CW'(rsp_push);
                if (rsp_drop)
                    drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_redirects <= '0;
            stat_starve    <= '0;
        end else begin
            if (redirect && stat_redirects != '1)
                stat_redirects <= stat_redirects + 32'd1;
            if (instr_ready && !instr_valid && !redirect && stat_starve != '1)
                stat_starve <= stat_starve + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Self-checking bench for cpu_fetch_queue: in-order memory model with random latency, stream model keyed on redirect targets.
module tb_cpu_fetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        jal, jalr, branch, branch_taken;
    logic [31:0] branch_target, jalr_target;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, pc_out;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_redirects, stat_starve;
`endif

    always #5 clk = ~clk;

    cpu_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .jal(jal), .jalr(jalr), .branch(branch), .branch_taken(branch_taken),
        .branch_target(branch_target), .jalr_target(jalr_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc_out(pc_out)
`ifdef FETCH_STATS_EN
        , .stat_redirects(stat_redirects), .stat_starve(stat_starve)
`endif
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct {
        logic j, jr, br, tk;
        logic [31:0] bt, jt;
        logic redir;
        logic [31:0] pc;
    } vec_t;

    mreq_t       memq [$];
    logic [31:0] pc_log [$];
    int          edge_n, n_checks, n_fail, pops;
    int          lat_lo, lat_hi, rdy_pct, dec_pct;
    logic [31:0] exp_pc, exp_req_pc, hold_addr;
    logic        hold_vld;
    int          first_acc, first_iv;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs at negedge, sample before the edge, update the model after it.
    task automatic cycle(input logic j, input logic jr, input logic br, input logic tk,
                         input logic [31:0] bt, input logic [31:0] jt);
        logic        redir, acc;
        logic [31:0] tgt;
        @(negedge clk);
        jal = j; jalr = jr; branch = br; branch_taken = tk;
        branch_target = bt; jalr_target = jt;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        instr_ready    = ($urandom_range(99) < dec_pct);
        if (memq.size() != 0 && memq[0].due <= edge_n + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
            memq.delete(0);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
        end
        #2;
        redir = jr | j | (br & tk);
        tgt   = (jr ? jt : bt) & ~32'h3;
        if (redir) begin
            check("redirect_req_valid", imem_req_valid, 1'b0);
            check("redirect_instr_valid", instr_valid, 1'b0);
        end
        if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_pc);
        if (hold_vld && !redir) begin
            check("hold_valid", imem_req_valid, 1'b1);
            check("hold_addr", imem_req_addr, hold_addr);
        end
        if (instr_valid && first_iv < 0) first_iv = edge_n + 1;
        if (instr_valid && instr_ready) begin
            check("pc_out", pc_out, exp_pc);
            check("instr", instr, mem_word(exp_pc));
            pc_log.push_back(pc_out);
            exp_pc += 32'd4;
            pops++;
        end
        acc       = imem_req_valid & imem_req_ready;
        hold_vld  = imem_req_valid & ~imem_req_ready;
        hold_addr = imem_req_addr;
        @(posedge clk);
        edge_n++;
        if (acc) begin
            memq.push_back('{imem_req_addr, edge_n + $urandom_range(lat_hi, lat_lo)});
            exp_req_pc += 32'd4;
            if (first_acc < 0) first_acc = edge_n;
        end
        if (redir) begin
            exp_req_pc = tgt;
            exp_pc     = tgt;
            hold_vld   = 1'b0;
        end
        if (memq.size() > DEPTH) check("inflight_bound", memq.size(), DEPTH);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic restart_model();
        memq.delete();
        pc_log.delete();
        exp_pc = RESET_PC; exp_req_pc = RESET_PC;
        hold_vld = 1'b0;
        first_acc = -1; first_iv = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, imem_req_valid, 1'b0);
        check({tag, "_req_addr"}, imem_req_addr, RESET_PC);
        check({tag, "_instr_valid"}, instr_valid, 1'b0);
        check({tag, "_instr"}, instr, 32'h0);
        check({tag, "_pc_out"}, pc_out, 32'h0);
    endtask

    initial begin
        vec_t vecs [7];
        int   base, found;
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h100,      32'h0,   1'b1, 32'h100};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h60,       32'h40,  1'b1, 32'h40};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h80,       32'h200, 1'b1, 32'h200};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h300,      32'h0,   1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h43,       32'h0,   1'b1, 32'h40};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h57,  1'b1, 32'h54};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF8, 32'h0,   1'b1, 32'hFFFFFFF8};

        n_checks = 0; n_fail = 0; pops = 0; edge_n = 0;
        reset = 1'b0;
        jal = 0; jalr = 0; branch = 0; branch_taken = 0; branch_target = 0; jalr_target = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; instr_ready = 0;
        restart_model();
        #1 check_reset_outputs("reset");
        @(posedge clk); #2 reset = 1'b1;

        // Straight-line fetch, latency 1, everything ready.
        lat_lo = 1; lat_hi = 1; rdy_pct = 100; dec_pct = 100;
        base = pops;
        idle(30);
        check("first_fetch_latency", first_iv - first_acc, 2);
        check("pc_seq_0", pc_log[0], 32'h0);
        check("pc_seq_2", pc_log[2], 32'h8);
        check("throughput", (pops - base) >= 25, 1'b1);

        // Decode stalled: queue fills to DEPTH and issue stops.
        dec_pct = 0;
        idle(20);
        check("fill_req_stall", imem_req_valid, 1'b0);
        check("fill_instr_valid", instr_valid, 1'b1);
        rdy_pct = 0; dec_pct = 100; base = pops;
        idle(10);
        check("fill_depth", pops - base, DEPTH);
        rdy_pct = 100;
        idle(10);

        // jal while two requests are in flight.
        lat_lo = 3; lat_hi = 3;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (memq.size() == 2) found = 1;
            else idle(1);
        end
        check("jal_two_inflight", found, 1);
        pc_log.delete();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
        idle(12);
        check("jal_enough_pops", pc_log.size() >= 2, 1'b1);
        if (pc_log.size() >= 2) begin
            check("jal_first_pc", pc_log[0], 32'h20);
            check("jal_second_pc", pc_log[1], 32'h24);
        end

        // Redirect table: priority, masking, non-taken branch, address wrap.
        for (int v = 0; v < 7; v++) begin
            logic [31:0] cont;
            lat_lo = 1; lat_hi = 2; rdy_pct = 80; dec_pct = 90;
            idle(6);
            cont = exp_pc;
            pc_log.delete();
            cycle(vecs[v].j, vecs[v].jr, vecs[v].br, vecs[v].tk, vecs[v].bt, vecs[v].jt);
            idle(14);
            check($sformatf("vec%0d_has_pop", v), pc_log.size() != 0, 1'b1);
            if (pc_log.size() != 0)
                check($sformatf("vec%0d_first_pc", v), pc_log[0], vecs[v].redir ? vecs[v].pc : cont);
        end

        // Latency 3 with request ready toggling.
        lat_lo = 3; lat_hi = 3; rdy_pct = 50; dec_pct = 100;
        pc_log.delete();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 300 && pc_log.size() < 16; i++) idle(1);
        check("lat3_count", pc_log.size() >= 16, 1'b1);
        if (pc_log.size() >= 16) check("lat3_last_pc", pc_log[15], 32'h3C);

        // Random traffic with occasional redirects.
        lat_lo = 1; lat_hi = 5; rdy_pct = 60; dec_pct = 60;
        base = pops;
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(99);
            if (r < 4) begin
                int          kind;
                logic [31:0] t1, t2;
                kind = $urandom_range(3);
                t1 = $urandom() & 32'h0000_0FFF;
                t2 = $urandom() & 32'h0000_0FFF;
                cycle(kind == 0, kind == 1, kind >= 2, kind == 2 || kind == 1, t1, t2);
            end else begin
                idle(1);
            end
        end
        check("random_progress", (pops - base) > 300, 1'b1);

        // Reset mid-burst.
        lat_lo = 2; lat_hi = 2; rdy_pct = 100; dec_pct = 100;
        idle(5);
        #1 reset = 1'b0;
        imem_rsp_valid = 1'b0;
        #1 check_reset_outputs("midreset");
        restart_model();
        @(posedge clk); edge_n++; #2 reset = 1'b1;
        idle(10);
        check("midreset_has_pop", pc_log.size() != 0, 1'b1);
        if (pc_log.size() != 0) check("midreset_first_pc", pc_log[0], RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cpu_fetch_queue.md
Name: cpu_fetch_queue

Overview:
Parametrised successor to the single-cycle fetch stage. Generates the PC and issues word requests over a valid/ready instruction-memory port that tolerates variable latency. Buffers returned instructions in a DEPTH-entry prefetch queue toward decode. Applies jal/jalr/branch redirects with queue flush and drops in-flight responses from the old path.

Parameters:
XLEN, 32, address/data width (≥32)
DEPTH, 4, prefetch queue entries (power of two, ≥2); also bounds requests in flight
RESET_PC, 32'h00000000, PC after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
jal  in  1  unconditional jump; target = branch_target
jalr  in  1  register jump; target = jalr_target
branch  in  1  conditional branch resolved this cycle
branch_taken  in  1  qualifies branch
branch_target  in  XLEN  target for jal / taken branch
jalr_target  in  XLEN  target for jalr
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word address of request
imem_rsp_valid  in  1  response valid (in order, one per accepted request, ≥1 cycle after acceptance)
imem_rsp_data  in  XLEN  instruction word
instr_valid  out  1  queue head valid toward decode
instr_ready  in  1  decode accepts head
instr  out  XLEN  head instruction
pc_out  out  XLEN  PC of head instruction

Behaviour:
- Reset (reset=0, async): fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0; imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, pc_out=0.
- redirect = jalr | jal | (branch & branch_taken). Priority: jalr > jal > branch. Target bits [1:0] forced to 0.
- Issue: imem_req_valid=1 when !redirect and (count + outstanding) < DEPTH. imem_req_addr=fetch_pc. Request accepted on valid&ready: fetch_pc += 4 (mod 2^XLEN), outstanding+1.
- Response: the stored PC is the accepted address, kept in a parallel PC FIFO of depth DEPTH. If drop_cnt>0, the response is discarded and drop_cnt−1. Otherwise data and PC are pushed to the queue. Credit rule guarantees no overflow.
- Dequeue: on instr_valid & instr_ready, pop the head. Push and pop in the same cycle leave count unchanged. A response to an empty queue becomes visible the next cycle; there is no bypass, so minimum fetch latency is memory latency + 1.
- Redirect cycle:
  - imem_req_valid and instr_valid are forced 0 combinationally.
  - At the edge: queue flushed, fetch_pc=target, drop_cnt = outstanding − (rsp_valid this cycle ? 1 : 0) + existing drop_cnt accounting. Equivalently, every request outstanding at the edge is dropped.
  - A request accepted in the same cycle cannot occur because valid is 0.
- Back-to-back redirects: the last one wins; drop accounting accumulates.
- Full queue with instr_ready=0: issue stalls; outstanding responses still land because credit reserves them.
- Reset mid-transaction: all state cleared. The memory is reset from the same net, so no stale responses arrive.
- Invariant: count + outstanding + drop_cnt ≤ 2·DEPTH. drop_cnt width = clog2(DEPTH)+1.

Optional Feature:
FETCH_STATS_EN. When defined, adds two outputs:
- stat_redirects (32): increments per redirect cycle.
- stat_starve (32): increments when instr_ready=1 & instr_valid=0 & !redirect.

Both counters saturate at 32'hFFFFFFFF and reset to 0. When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset release, memory ready=1, latency 1, ready decode → pc_out sequence 0x0,0x4,0x8,… with instr matching memory; first instr_valid 2 cycles after first acceptance.
- Decode instr_ready=0 for 20 cycles → queue fills to DEPTH=4, imem_req_valid drops once count+outstanding=4; no lost or duplicated words after release.
- jal with branch_target=0x20 while 2 requests outstanding → both stale responses dropped; next pc_out=0x20, then 0x24.
- Same-cycle jalr (0x40) and taken branch (0x60) → pc_out resumes at 0x40.
- Memory latency 3 with imem_req_ready toggling → imem_req_addr held stable while unaccepted; in-order delivery of 0x0..0x3C.
- Target 0x43 → fetch resumes at 0x40. Assert reset low mid-burst → all outputs return to reset values immediately, and fetch restarts at RESET_PC.
